// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: a Moore FSM sequences fetch, decode, execute and writeback.
// Branch pc_write is the only output qualified combinationally (by the ALU zero flag).
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] function_,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] write_data,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_operation,
  output logic [1:0] pc_src,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_LWWB  = 4'd4,
    S_MWR   = 4'd5,
    S_REX   = 4'd6,
    S_RWB   = 4'd7,
    S_BEQ   = 4'd8,
    S_BNE   = 4'd9,
    S_JMP   = 4'd10,
    S_JAL   = 4'd11,
    S_JR    = 4'd12,
    S_IEX   = 4'd13,
    S_IWB   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MADDR;
          OP_RTYPE:         state_d = (function_ == FN_JR) ? S_JR : S_REX;
          OP_BEQ:           state_d = S_BEQ;
          OP_BNE:           state_d = S_BNE;
          OP_J:             state_d = S_JMP;
          OP_JAL:           state_d = S_JAL;
          OP_ADDI, OP_SLTI: state_d = S_IEX;
          default:          state_d = S_IF;
        endcase
      end
      // Opcode is held in the instruction register, so it is still valid here.
      S_MADDR: state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_LWWB;
      S_REX:   state_d = S_RWB;
      S_IEX:   state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    write_data    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_operation = 3'b000;
    pc_src        = 2'b00;
    // Gating on rst keeps every strobe low for the whole reset pulse, even mid-instruction.
    if (rst) begin
      case (state_q)
        S_IF: begin
          mem_read      = 1'b1;
          ir_write      = 1'b1;
          alu_src_b     = 2'b01;
          alu_operation = ALU_ADD;
          pc_write      = 1'b1;
        end
        S_ID: begin
          alu_src_b     = 2'b11;
          alu_operation = ALU_ADD;
        end
        S_MADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b10;
          alu_operation = ALU_ADD;
        end
        S_MRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_LWWB: begin
          reg_write  = 1'b1;
          write_data = 2'b10;
        end
        S_MWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          case (function_)
            FN_ADD:  alu_operation = ALU_ADD;
            FN_SUB:  alu_operation = ALU_SUB;
            FN_AND:  alu_operation = ALU_AND;
            FN_OR:   alu_operation = ALU_OR;
            FN_SLT:  alu_operation = ALU_SLT;
            default: alu_operation = ALU_ADD;
          endcase
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BEQ, S_BNE: begin
          alu_src_a     = 1'b1;
          alu_operation = ALU_SUB;
          pc_src        = 2'b01;
          pc_write      = (state_q == S_BEQ) ? zero : !zero;
        end
        S_JMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        // PC was already incremented in IF, so the link value written to $31 is PC+4.
        S_JAL: begin
          pc_src     = 2'b10;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          write_data = 2'b01;
        end
        S_JR: begin
          pc_src   = 2'b11;
          pc_write = 1'b1;
        end
        S_IEX: begin
          alu_src_a     = 1'b1;
          alu_src_b     = 2'b10;
          alu_operation = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_IWB: begin
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_out = state_q;

endmodule
